a23_cache_flush_ctrl: RTL and testbench
=======================================

Name: a23_cache_flush_ctrl

Overview:
Sits directly downstream of the CP15 coprocessor and consumes its cache_enable, cache_flush and cacheable_area outputs. Sequences a full tag invalidation of the unified cache, one line index per cycle across all ways, on a flush pulse and after reset. Stalls the core while it runs. Supplies a registered per-access "cacheable" decision to the cache from the 2 MB-region bitmap.

Parameters:
CACHE_LINES, 256, lines per way; power of 2, range 4..1024; index width IDX_W = log2(CACHE_LINES).
CACHE_WAYS, 4, number of ways; all ways are cleared in parallel.
INIT_ON_RESET, 1, 1 = run a full invalidation sweep automatically on reset release.

Ports:
i_clk  in  1  core clock
i_rst  in  1  reset; asynchronous assert, active-high
i_fetch_stall  in  1  global core stall; freezes request sampling, not the sweep
i_cache_enable  in  1  coprocessor cache-on bit
i_cache_flush  in  1  coprocessor flush pulse (CP15 reg1 write)
i_cacheable_area  in  32  region bitmap; bit n covers addresses n*2MB .. n*2MB+2MB-1
i_req_valid  in  1  core access request
i_req_address  in  32  core access address
o_cacheable  out  1  registered: access is cacheable
o_flush_busy  out  1  sweep in progress; core must stall
o_tag_wr_en  out  1  tag RAM write strobe
o_tag_wr_index  out  IDX_W  tag RAM line index
o_tag_wr_way_mask  out  CACHE_WAYS  ways written (all ones during sweep)
o_flush_done  out  1  one-cycle pulse on sweep completion

Behaviour:
- Reset values: state IDLE or INIT, index 0, pending 0; all outputs 0.
- If INIT_ON_RESET=1, state resets to INIT and o_flush_busy is 1 in the first cycle after i_rst deasserts.
- States: IDLE, INIT, SWEEP, DONE. INIT behaves exactly like SWEEP; it is kept separate only for debug visibility.
- IDLE -> SWEEP when i_cache_flush=1; index loaded with 0.
- SWEEP/INIT, every cycle:
  - o_tag_wr_en=1, o_tag_wr_index=index, o_tag_wr_way_mask all ones; written tag valid bit is 0.
  - Index increments by 1.
  - At index=CACHE_LINES-1, go to DONE. No wrap is emitted.
- The sweep is CACHE_LINES cycles long and ignores i_fetch_stall.
- DONE, one cycle: o_flush_done=1, o_tag_wr_en=0, o_flush_busy=0.
  - If pending=1: clear pending and go to SWEEP with index 0.
  - Otherwise go to IDLE.
- o_flush_busy=1 in SWEEP and INIT only. It is a registered state decode with no combinational path from i_cache_flush, so the first busy cycle follows the flush pulse by one clock.
- Flush arriving during SWEEP/INIT: sets pending; the current sweep is not restarted. Multiple flushes during one sweep collapse to a single extra sweep.
- Flush arriving in DONE: sets pending, so a new sweep starts next cycle.
- Cacheable decision, registered, 1-cycle latency:
  - Updated only when i_fetch_stall=0.
  - o_cacheable = i_req_valid & i_cache_enable & ~o_flush_busy & (i_req_address[31:26]==0) & i_cacheable_area[i_req_address[25:21]].
  - Addresses at or above 64 MB are never cacheable.
  - When i_fetch_stall=1, o_cacheable holds its value.
- i_cache_enable has no effect on the sweep. A flush with the cache disabled still sweeps.
- i_rst asserted mid-sweep: immediate return to reset state. The sweep restarts from index 0 only if INIT_ON_RESET=1.

Optional Feature:
- Macro A23_FLUSH_PERF_EN.
- Defined: adds output o_flush_count[15:0], which increments on each o_flush_done pulse and saturates at 16'hFFFF. Also adds o_stall_cycles[31:0], which increments every cycle o_flush_busy=1 and wraps. Both reset to 0 on i_rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package a23_cache_pkg:
  - state encoding constants A23_FLUSH_IDLE=2'd0, INIT=2'd1, SWEEP=2'd2, DONE=2'd3
  - A23_REGION_SHIFT=21
  - A23_REGION_BITS=5
- Natural sub-module: a23_region_decode, a combinational address-to-region-bit lookup. It is reused by the cache for updateable and disruptive area checks.

Test Plan:
- Reset release with INIT_ON_RESET=1, CACHE_LINES=256 -> o_tag_wr_en high for 256 consecutive cycles with index 0..255, then o_flush_done pulse, then busy low.
- After idle, a 1-cycle i_cache_flush -> busy rises next cycle; sweep of 256 writes; single done pulse.
- Second flush pulse at index 100 and third at index 200 -> after DONE, exactly one further 256-cycle sweep starts immediately.
- i_cache_enable=1, area=32'h0000_0005, addresses 0x0010_0000, 0x0030_0000, 0x0040_0000, 0x0400_0000 -> o_cacheable next cycle = 1, 0, 1, 0 respectively.
- Same accesses with i_fetch_stall=1 -> o_cacheable holds its prior value. Access during busy -> 0.
- i_rst pulse at index 50 -> outputs zero asynchronously; sweep restarts from 0 after release. With A23_FLUSH_PERF_EN, o_flush_count=0 after reset and =1 after the sweep.

Source files
------------

// File: rtl/a23_cache_pkg.sv
// ============================================================================
// Module : a23_cache_pkg
// Brief  : Shared flush-FSM state encoding and cacheable-region geometry.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package a23_cache_pkg;

  typedef logic [1:0] a23_flush_state_t;

  localparam a23_flush_state_t A23_FLUSH_IDLE  = 2'd0;
  localparam a23_flush_state_t A23_FLUSH_INIT  = 2'd1;
  localparam a23_flush_state_t A23_FLUSH_SWEEP = 2'd2;
  localparam a23_flush_state_t A23_FLUSH_DONE  = 2'd3;

  // Each bitmap bit covers one 2 MB region; 32 regions span the low 64 MB.
  localparam int A23_REGION_SHIFT = 21;
  localparam int A23_REGION_BITS  = 5;
  localparam int A23_ADDR_HI_W    = 32 - A23_REGION_SHIFT;

endpackage : a23_cache_pkg

`default_nettype wire

// File: rtl/a23_region_decode.sv
// ============================================================================
// Module : a23_region_decode
// Brief  : Address-to-region-bit lookup; addresses at or above 64 MB never hit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module a23_region_decode
  import a23_cache_pkg::*;
(
  input  logic [A23_ADDR_HI_W-1:0] i_addr_hi,
  input  logic [31:0]              i_area,
  output logic                     o_hit
);

  logic                       w_low_64mb;
  logic [A23_REGION_BITS-1:0] w_region;

  assign w_low_64mb = (i_addr_hi[A23_ADDR_HI_W-1:A23_REGION_BITS] == '0);
  assign w_region   = i_addr_hi[A23_REGION_BITS-1:0];
  assign o_hit      = w_low_64mb & i_area[w_region];

endmodule : a23_region_decode

`default_nettype wire

// File: rtl/a23_cache_flush_ctrl.sv
// ============================================================================
// Module : a23_cache_flush_ctrl
// Brief  : Tag-invalidation sequencer and registered cacheable decision.
//          Optional perf counters enabled by defining A23_FLUSH_PERF_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module a23_cache_flush_ctrl
  import a23_cache_pkg::*;
#(
  parameter int CACHE_LINES   = 256,
  parameter int CACHE_WAYS    = 4,
  parameter bit INIT_ON_RESET = 1'b1,
  localparam int IDX_W        = $clog2(CACHE_LINES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fetch_stall,
  input  logic                  i_cache_enable,
  input  logic                  i_cache_flush,
  input  logic [31:0]           i_cacheable_area,
  input  logic                  i_req_valid,
  input  logic [31:0]           i_req_address,
  output logic                  o_cacheable,
  output logic                  o_flush_busy,
  output logic                  o_tag_wr_en,
  output logic [IDX_W-1:0]      o_tag_wr_index,
  output logic [CACHE_WAYS-1:0] o_tag_wr_way_mask,
  output logic                  o_flush_done
`ifdef A23_FLUSH_PERF_EN
  ,output logic [15:0]          o_flush_count
  ,output logic [31:0]          o_stall_cycles
`endif
);

  localparam logic [IDX_W-1:0] c_LAST_IDX     = IDX_W'(CACHE_LINES - 1);
  localparam a23_flush_state_t c_RESET_STATE  = INIT_ON_RESET ? A23_FLUSH_INIT
                                                              : A23_FLUSH_IDLE;

  a23_flush_state_t state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             pending_q, pending_d;
  logic             live_q;
  logic             cacheable_q;
  logic             w_sweep;
  logic             w_region_hit;
  logic             w_unused_addr;

  // live_q keeps the reset-time INIT state silent until the first clock
  // after reset release, so every output reads 0 while i_rst is high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= c_RESET_STATE;
      index_q   <= '0;
      pending_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      pending_q <= pending_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    pending_d = pending_q;
    case (state_q)
      A23_FLUSH_IDLE: begin
        if (i_cache_flush) begin
          state_d = A23_FLUSH_SWEEP;
          index_d = '0;
        end
      end
      A23_FLUSH_INIT, A23_FLUSH_SWEEP: begin
        if (live_q) begin
          if (i_cache_flush) pending_d = 1'b1;
          index_d = index_q + IDX_W'(1);
          if (index_q == c_LAST_IDX) state_d = A23_FLUSH_DONE;
        end
      end
      default: begin
        index_d = '0;
        if (pending_q || i_cache_flush) begin
          pending_d = 1'b0;
          state_d   = A23_FLUSH_SWEEP;
        end else begin
          state_d   = A23_FLUSH_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_sweep           = (state_q == A23_FLUSH_SWEEP) ||
                        (live_q && (state_q == A23_FLUSH_INIT));
    o_flush_busy      = w_sweep;
    o_tag_wr_en       = w_sweep;
    o_tag_wr_index    = index_q;
    o_tag_wr_way_mask = {CACHE_WAYS{w_sweep}};
    o_flush_done      = (state_q == A23_FLUSH_DONE);
  end

  a23_region_decode u_region_decode (
    .i_addr_hi (i_req_address[31:A23_REGION_SHIFT]),
    .i_area    (i_cacheable_area),
    .o_hit     (w_region_hit)
  );

  assign w_unused_addr = ^i_req_address[A23_REGION_SHIFT-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cacheable_q <= 1'b0;
    end else if (!i_fetch_stall) begin
      cacheable_q <= i_req_valid & i_cache_enable & ~w_sweep & w_region_hit;
    end
  end

  assign o_cacheable = cacheable_q;

`ifdef A23_FLUSH_PERF_EN
  logic [15:0] flush_count_q;
  logic [31:0] stall_cycles_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      flush_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (o_flush_done && (flush_count_q != 16'hFFFF))
        flush_count_q <= flush_count_q + 16'd1;
      if (w_sweep)
        stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign o_flush_count  = flush_count_q;
  assign o_stall_cycles = stall_cycles_q;
`endif

endmodule : a23_cache_flush_ctrl

`default_nettype wire

// File: tb/tb_a23_cache_flush_ctrl.sv
// ============================================================================
// Module : tb_a23_cache_flush_ctrl
// Brief  : Scoreboard bench for the flush sequencer and cacheable decision.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_a23_cache_flush_ctrl;

  localparam int LINES     = 256;
  localparam int WAYS      = 4;
  localparam int IDX_W     = 8;
  localparam int DONE_MARK = LINES;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fetch_stall = 1'b0;
  logic             cache_enable = 1'b0;
  logic             cache_flush = 1'b0;
  logic [31:0]      cacheable_area = '0;
  logic             req_valid = 1'b0;
  logic [31:0]      req_address = '0;
  logic             cacheable;
  logic             flush_busy;
  logic             tag_wr_en;
  logic [IDX_W-1:0] tag_wr_index;
  logic [WAYS-1:0]  tag_wr_way_mask;
  logic             flush_done;
`ifdef A23_FLUSH_PERF_EN
  logic [15:0]      flush_count;
  logic [31:0]      stall_cycles;
`endif

  a23_cache_flush_ctrl #(
    .CACHE_LINES   (LINES),
    .CACHE_WAYS    (WAYS),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_fetch_stall     (fetch_stall),
    .i_cache_enable    (cache_enable),
    .i_cache_flush     (cache_flush),
    .i_cacheable_area  (cacheable_area),
    .i_req_valid       (req_valid),
    .i_req_address     (req_address),
    .o_cacheable       (cacheable),
    .o_flush_busy      (flush_busy),
    .o_tag_wr_en       (tag_wr_en),
    .o_tag_wr_index    (tag_wr_index),
    .o_tag_wr_way_mask (tag_wr_way_mask),
    .o_flush_done      (flush_done)
`ifdef A23_FLUSH_PERF_EN
    ,.o_flush_count    (flush_count)
    ,.o_stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];
  logic cach_q[$];
  logic prev_ev = 1'b0;
  logic ev;

  typedef struct {
    logic [31:0] addr;
    logic        stall;
    logic        valid;
    logic        en;
    logic [31:0] area;
    logic        exp;
  } req_t;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Event monitor: samples 1 unit after each rising edge and pops the scoreboard.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      ev = tag_wr_en | flush_done;
      if (prev_ev && exp_q.size() > 0) check_val("contiguous", {31'd0, ev}, 32'd1);
      if (tag_wr_en) begin
        check_val("busy_with_wr", {31'd0, flush_busy}, 32'd1);
        check_val("way_mask", {28'd0, tag_wr_way_mask}, 32'hF);
        if (exp_q.size() == 0) check_val("unexpected_wr", 32'(exp_q.size()), 32'd1);
        else check_val("wr_index", {24'd0, tag_wr_index}, exp_q.pop_front());
      end else begin
        check_val("busy_idle", {31'd0, flush_busy}, 32'd0);
      end
      if (flush_done) begin
        check_val("done_no_wr", {31'd0, tag_wr_en}, 32'd0);
        if (exp_q.size() == 0) check_val("unexpected_done", 32'(exp_q.size()), 32'd1);
        else check_val("done_pulse", DONE_MARK, exp_q.pop_front());
      end
      prev_ev = ev;
    end else begin
      prev_ev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_sweep();
    for (int i = 0; i < LINES; i++) exp_q.push_back(i);
    exp_q.push_back(DONE_MARK);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || flush_busy) && n < budget) begin
      tick();
      n++;
    end
    check_val("drain_left", 32'(exp_q.size()), 32'd0);
    tick();
    check_val("busy_after", {31'd0, flush_busy}, 32'd0);
  endtask

  task automatic wait_index(input int idx, input int budget);
    int n = 0;
    while (!(tag_wr_en && tag_wr_index == IDX_W'(idx)) && n < budget) begin
      tick();
      n++;
    end
    check_val("reach_index", {24'd0, tag_wr_index}, 32'(idx));
  endtask

  task automatic pulse_flush(input bit push);
    cache_flush = 1'b1;
    if (push) push_sweep();
    tick();
    cache_flush = 1'b0;
  endtask

  task automatic run_req(input req_t r, input string tag);
    req_address    = r.addr;
    fetch_stall    = r.stall;
    req_valid      = r.valid;
    cache_enable   = r.en;
    cacheable_area = r.area;
    cach_q.push_back(r.exp);
    tick();
    check_val(tag, {31'd0, cacheable}, {31'd0, cach_q.pop_front()});
  endtask

  req_t reqs[11];

  initial begin
    reqs[0]  = '{32'h0010_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b1};
    reqs[1]  = '{32'h0030_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b0};
    reqs[2]  = '{32'h0040_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b1};
    reqs[3]  = '{32'h0400_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b0};
    reqs[4]  = '{32'h0010_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b1};
    reqs[5]  = '{32'h0030_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0005, 1'b1};
    reqs[6]  = '{32'h0400_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0005, 1'b1};
    reqs[7]  = '{32'h0010_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0005, 1'b0};
    reqs[8]  = '{32'h0010_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0005, 1'b0};
    reqs[9]  = '{32'h03FF_FFFF, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1};
    reqs[10] = '{32'hFFE0_0000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    check_val("rst_busy", {31'd0, flush_busy}, 32'd0);
    check_val("rst_wr_en", {31'd0, tag_wr_en}, 32'd0);
    check_val("rst_index", {24'd0, tag_wr_index}, 32'd0);
    check_val("rst_mask", {28'd0, tag_wr_way_mask}, 32'd0);
    check_val("rst_done", {31'd0, flush_done}, 32'd0);
    check_val("rst_cacheable", {31'd0, cacheable}, 32'd0);

    // Init sweep on reset release
    tick();
    rst = 1'b0;
    push_sweep();
`ifdef A23_FLUSH_PERF_EN
    check_val("perf_count_rst", {16'd0, flush_count}, 32'd0);
`endif
    tick();
    check_val("init_busy", {31'd0, flush_busy}, 32'd1);
    wait_drain(400);

    // Single flush from idle, with cache disabled
    cache_enable = 1'b0;
    pulse_flush(1'b1);
    check_val("busy_rise", {31'd0, flush_busy}, 32'd1);
    wait_drain(400);

    // Flushes at index 100 and 200 collapse into one extra sweep
    pulse_flush(1'b1);
    wait_index(100, 300);
    pulse_flush(1'b1);
    wait_index(200, 300);
    pulse_flush(1'b0);
    wait_drain(700);

    // Cacheable decision table
    for (int i = 0; i < 11; i++) run_req(reqs[i], $sformatf("cacheable_%0d", i));

    // Access during a sweep is never cacheable
    req_valid = 1'b0;
    fetch_stall = 1'b0;
    pulse_flush(1'b1);
    run_req('{32'h0010_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b0}, "cacheable_busy");
    req_valid = 1'b0;
    wait_drain(400);

    // Reset in the middle of a sweep
    pulse_flush(1'b1);
    wait_index(50, 300);
    rst = 1'b1;
    #1;
    check_val("midrst_busy", {31'd0, flush_busy}, 32'd0);
    check_val("midrst_wr_en", {31'd0, tag_wr_en}, 32'd0);
    check_val("midrst_index", {24'd0, tag_wr_index}, 32'd0);
    check_val("midrst_mask", {28'd0, tag_wr_way_mask}, 32'd0);
`ifdef A23_FLUSH_PERF_EN
    check_val("perf_count_midrst", {16'd0, flush_count}, 32'd0);
`endif
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    push_sweep();
    wait_drain(400);
`ifdef A23_FLUSH_PERF_EN
    check_val("perf_count_one", {16'd0, flush_count}, 32'd1);
    check_val("perf_stall", stall_cycles, 32'(LINES));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_a23_cache_flush_ctrl

`default_nettype wire
